// File: rtl/sddr_init_seq_if.sv
// sddr_init_seq_if: control-register write port between the init sequencer and the DDR controller.
interface sddr_init_seq_if;
   logic        valid;
   logic [15:0] address;
   logic [31:0] data;
   logic        write;
   logic        ack;
   modport master (output valid, address, data, write, input ack);
   modport slave  (input valid, address, data, write, output ack);
endinterface

// File: rtl/sddr_init_seq.sv
// sddr_init_seq: DDR3 power-up/MRS/ZQCL sequencer driving the controller's register port.
// Define SDDR_INIT_ZQCL_EN to issue ZQCL after the MR0 MRS.
module sddr_init_seq #(
   parameter int          BANK_BITS = 3,
   parameter logic [15:0] MR0       = 16'h0000,
   parameter logic [15:0] MR1       = 16'h0000,
   parameter logic [15:0] MR2       = 16'h0000,
   parameter logic [15:0] MR3       = 16'h0000,
   parameter int          T_RESET   = 20000,
   parameter int          T_CKE     = 50000,
   parameter int          T_XPR     = 30,
   parameter int          T_MRD     = 4,
   parameter int          T_MOD     = 12,
   parameter int          T_ZQINIT  = 512
) (
   input  logic           cpu_clock_i,
   input  logic           cpu_reset_n_i,
   input  logic           restart_i,
   sddr_init_seq_if.master ctrl_cmd,
   output logic           init_busy_o,
   output logic           init_done_o
);
   typedef enum logic [3:0] {
      S_RST, S_REL, S_CKE, S_NOP, S_MR_ADDR, S_MR_CMD, S_ZQ_ADDR, S_ZQ_CMD, S_RUN, S_DONE
   } state_t;
`ifdef SDDR_INIT_ZQCL_EN
   localparam state_t S_AFTER_MR = S_ZQ_ADDR;
`else
   localparam state_t S_AFTER_MR = S_RUN;
`endif
   localparam logic [15:0] A_RST  = 16'h0000;
   localparam logic [15:0] A_CMD  = 16'h0004;
   localparam logic [15:0] A_ADDR = 16'h0008;
   localparam logic [31:0] W_RST  = 32'h0000_0000;
   localparam logic [31:0] W_REL  = 32'h0000_0003;
   localparam logic [31:0] W_CKE  = 32'h0000_0023;
   localparam logic [31:0] W_RUN  = 32'h0000_002B;
   localparam logic [31:0] C_NOP  = 32'h0000_0007;
   localparam logic [31:0] C_MRS  = 32'h0000_0000;
   localparam logic [31:0] C_ZQCL = 32'h0000_0006;
   localparam logic [31:0] W_ZQA  = 32'h0000_0400;

   state_t                r_state, w_state, w_next;
   logic [31:0]           r_cnt, w_cnt, w_wait, w_data;
   logic [15:0]           w_addr, w_mr;
   logic [1:0]            r_idx, w_idx;
   logic [BANK_BITS-1:0]  w_bank;
   logic                  r_valid, w_valid, r_busy, w_busy, r_done, w_done, w_accept;

   // MRS order is MR2, MR3, MR1, MR0; bank number follows the register number
   always_comb begin
      w_bank = BANK_BITS'(r_idx == 2'd0 ? 2 : r_idx == 2'd1 ? 3 : r_idx == 2'd2 ? 1 : 0);
      w_mr   = r_idx == 2'd0 ? MR2 : r_idx == 2'd1 ? MR3 : r_idx == 2'd2 ? MR1 : MR0;
      w_addr = A_RST;
      w_data = '0;
      w_wait = '0;
      w_next = S_DONE;
      case (r_state)
         S_RST:     begin w_data = W_RST; w_wait = 32'(T_RESET); w_next = S_REL; end
         S_REL:     begin w_data = W_REL; w_wait = 32'(T_CKE); w_next = S_CKE; end
         S_CKE:     begin w_data = W_CKE; w_next = S_NOP; end
         S_NOP:     begin w_addr = A_CMD; w_data = C_NOP; w_wait = 32'(T_XPR); w_next = S_MR_ADDR; end
         S_MR_ADDR: begin
            w_addr = A_ADDR;
            w_data = {w_bank, {(16-BANK_BITS){1'b0}}, w_mr};
            w_next = S_MR_CMD;
         end
         S_MR_CMD:  begin
            w_addr = A_CMD;
            w_data = C_MRS;
            w_wait = r_idx == 2'd3 ? 32'(T_MOD) : 32'(T_MRD);
            w_next = r_idx == 2'd3 ? S_AFTER_MR : S_MR_ADDR;
         end
         S_ZQ_ADDR: begin w_addr = A_ADDR; w_data = W_ZQA; w_next = S_ZQ_CMD; end
         S_ZQ_CMD:  begin w_addr = A_CMD; w_data = C_ZQCL; w_wait = 32'(T_ZQINIT); w_next = S_RUN; end
         S_RUN:     begin w_data = W_RUN; w_next = S_DONE; end
         default:   w_next = S_DONE;
      endcase
      w_accept = r_valid & ctrl_cmd.ack;
      w_state  = r_state;
      w_cnt    = r_cnt == '0 ? '0 : r_cnt - 32'd1;
      w_idx    = r_idx;
      w_valid  = r_valid;
      w_done   = r_done;
      // valid re-arms on the edge the counter reaches 0, so a wait of T costs exactly T edges
      if (w_accept) begin
         w_state = w_next;
         w_cnt   = w_wait;
         w_idx   = r_state == S_MR_CMD ? r_idx + 2'd1 : r_idx;
         w_valid = w_wait == '0 && w_next != S_DONE;
         w_done  = w_next == S_DONE;
      end else if (r_state == S_DONE) begin
         w_state = restart_i ? S_RST : S_DONE;
         w_done  = !restart_i;
      end else if (!r_valid && r_cnt <= 32'd1) begin
         w_valid = 1'b1;
      end
      w_busy = w_state != S_DONE;
   end

   always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
      if (!cpu_reset_n_i) begin
         r_state <= S_RST;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_idx   <= w_idx;
         r_valid <= w_valid;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   assign ctrl_cmd.valid   = r_valid;
   assign ctrl_cmd.write   = r_valid;
   assign ctrl_cmd.address = w_addr;
   assign ctrl_cmd.data    = w_data;
   assign init_busy_o      = r_busy;
   assign init_done_o      = r_done;
endmodule

// File: tb/tb_sddr_init_seq.sv
// tb_sddr_init_seq: directed bench; DUT a uses short waits with ack stalls, DUT b uses zero waits.
module tb_sddr_init_seq;
   logic clk = 1'b0, rst_n = 1'b1, restart_a = 1'b0, restart_b = 1'b0;
   logic busy_a, done_a, busy_b, done_b;
   int total = 0, bad = 0, cyc = 0, base = 0;
   logic [15:0] la_addr [64], lb_addr [64];
   logic [31:0] la_data [64], lb_data [64];
   int          la_cyc  [64], lb_cyc  [64];
   int          la_n = 0, lb_n = 0;
   logic [47:0] exp_q [$];

   sddr_init_seq_if ifa ();
   sddr_init_seq_if ifb ();

   sddr_init_seq #(
      .BANK_BITS(3), .MR0(16'h1520), .MR1(16'h0044), .MR2(16'h0008), .MR3(16'h0000),
      .T_RESET(5), .T_CKE(2), .T_XPR(2), .T_MRD(2), .T_MOD(2), .T_ZQINIT(2)
   ) dut_a (
      .cpu_clock_i(clk), .cpu_reset_n_i(rst_n), .restart_i(restart_a),
      .ctrl_cmd(ifa), .init_busy_o(busy_a), .init_done_o(done_a)
   );

   sddr_init_seq #(
      .BANK_BITS(3), .MR0(16'h1520), .MR1(16'h0044), .MR2(16'h0008), .MR3(16'h0000),
      .T_RESET(0), .T_CKE(0), .T_XPR(0), .T_MRD(0), .T_MOD(0), .T_ZQINIT(0)
   ) dut_b (
      .cpu_clock_i(clk), .cpu_reset_n_i(rst_n), .restart_i(restart_b),
      .ctrl_cmd(ifb), .init_busy_o(busy_b), .init_done_o(done_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // transfers are logged mid-low-phase, stamped with the cycle of the accepting edge
   always begin
      @(negedge clk);
      #2;
      if (ifa.valid && ifa.ack && la_n < 64) begin
         la_addr[la_n] <= ifa.address;
         la_data[la_n] <= ifa.data;
         la_cyc[la_n]  <= cyc;
         la_n          <= la_n + 1;
      end
      if (ifb.valid && ifb.ack && lb_n < 64) begin
         lb_addr[lb_n] <= ifb.address;
         lb_data[lb_n] <= ifb.data;
         lb_cyc[lb_n]  <= cyc;
         lb_n          <= lb_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 500 && !done_a; i++) @(negedge clk);
      chk("done_a", 64'(done_a), 64'd1);
   endtask

   task automatic check_log(input int b);
      chk("a_count", 64'(la_n - b), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("a_w%0d", i), 64'({la_addr[b+i], la_data[b+i]}), 64'(exp_q[i]));
   endtask

   task automatic poll_cke_wait();
      for (int i = 0; i < 200 && !(!ifa.valid && ifa.data == 32'h23); i++) @(negedge clk);
      chk("cke_wait", 64'({ifa.valid, ifa.data}), 64'h23);
   endtask

   initial begin
      ifa.ack = 1'b1;
      ifb.ack = 1'b1;
      exp_q = {48'h0000_00000000, 48'h0000_00000003, 48'h0000_00000023, 48'h0004_00000007,
               48'h0008_40000008, 48'h0004_00000000, 48'h0008_60000000, 48'h0004_00000000,
               48'h0008_20000044, 48'h0004_00000000, 48'h0008_00001520, 48'h0004_00000000,
`ifdef SDDR_INIT_ZQCL_EN
               48'h0008_00000400, 48'h0004_00000006,
`endif
               48'h0000_0000002B};
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(ifa.valid), 64'd0);
      chk("rst_addr", 64'(ifa.address), 64'd0);
      chk("rst_data", 64'(ifa.data), 64'd0);
      chk("rst_write", 64'(ifa.write), 64'd0);
      chk("rst_busy", 64'(busy_a), 64'd0);
      chk("rst_done", 64'(done_a), 64'd0);
      chk("rst_valid_b", 64'(ifb.valid), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_valid", 64'(ifa.valid), 64'd1);
      chk("first_busy", 64'(busy_a), 64'd1);
      // hold off the first MRS command for 7 cycles
      for (int i = 0; i < 200 && !(ifa.valid && ifa.address == 16'h4 && ifa.data == 32'h0); i++)
         @(negedge clk);
      chk("mrs_seen", 64'({ifa.valid, ifa.address, ifa.data}), 64'({1'b1, 16'h4, 32'h0}));
      ifa.ack = 1'b0;
      repeat (7) begin
         @(negedge clk);
         chk("stall_hold", 64'({ifa.valid, ifa.write, ifa.address, ifa.data}), 64'({2'b11, 16'h4, 32'h0}));
      end
      ifa.ack = 1'b1;
      wait_done();
      chk("done_busy", 64'(busy_a), 64'd0);
      chk("done_valid", 64'(ifa.valid), 64'd0);
      check_log(0);
      chk("t_reset_gap", 64'(la_cyc[1] - la_cyc[0]), 64'd6);
      chk("stall_gap", 64'(la_cyc[5] - la_cyc[4]), 64'd8);
      chk("mrd_after_stall", 64'(la_cyc[6] - la_cyc[5]), 64'd3);
      chk("b_done", 64'(done_b), 64'd1);
      chk("b_count", 64'(lb_n), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("b_w%0d", i), 64'({lb_addr[i], lb_data[i]}), 64'(exp_q[i]));
      chk("b_cke_nop", 64'(lb_cyc[3] - lb_cyc[2]), 64'd1);
      chk("b_mr_pair", 64'(lb_cyc[5] - lb_cyc[4]), 64'd1);
      chk("b_contig", 64'(lb_cyc[exp_q.size()-1] - lb_cyc[0]), 64'(exp_q.size() - 1));
      // restart from DONE, with an ignored restart pulse mid-run
      base = la_n;
      restart_a = 1'b1;
      @(negedge clk);
      restart_a = 1'b0;
      chk("restart_done_fall", 64'(done_a), 64'd0);
      chk("restart_busy", 64'(busy_a), 64'd1);
      poll_cke_wait();
      restart_a = 1'b1;
      @(negedge clk);
      restart_a = 1'b0;
      chk("busy_restart_ignored", 64'(busy_a), 64'd1);
      wait_done();
      check_log(base);
      // asynchronous reset during the CKE wait
      restart_a = 1'b1;
      @(negedge clk);
      restart_a = 1'b0;
      poll_cke_wait();
      rst_n = 1'b0;
      #1;
      chk("async_rst", 64'({ifa.valid, ifa.write, busy_a, done_a, ifa.address, ifa.data}), 64'd0);
      repeat (2) @(negedge clk);
      base = la_n;
      rst_n = 1'b1;
      wait_done();
      check_log(base);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
